// File: rtl/regfile_scan_ctrl.sv
// Sequencer that dumps (reads and streams) or fills (writes a constant into) a register-file
// address range through the register file's external read and write ports.
module regfile_scan_ctrl #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
    input  logic [DATA_W-1:0] fill_val,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    // One extra counter bit so the last implemented address never wraps
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_ADDR = CNT_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        OUT,
        WR,
        DONE
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cur, cur_d;
    logic [CNT_W-1:0]    hi_q, hi_d;
    logic [CNT_W-1:0]    lo_c, hi_c;
    logic [DATA_W-1:0]   fill_q, fill_d;

    // Clamp requested range to implemented registers
    always_comb begin
        lo_c = (CNT_W'(addr_lo) > MAX_ADDR) ? MAX_ADDR : CNT_W'(addr_lo);
        hi_c = (CNT_W'(addr_hi) > MAX_ADDR) ? MAX_ADDR : CNT_W'(addr_hi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next state and next range/fill bookkeeping
    always_comb begin
        state_d = state;
        cur_d   = cur;
        hi_d    = hi_q;
        fill_d  = fill_q;
        case (state)
            IDLE: begin
                if (start) begin
                    cur_d  = lo_c;
                    hi_d   = hi_c;
                    fill_d = fill_val;
                    if (lo_c > hi_c) state_d = DONE;
                    else if (mode)   state_d = WR;
                    else             state_d = RD_ADDR;
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    if (cur == hi_q) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = cur + CNT_W'(1);
                        state_d = RD_ADDR;
                    end
                end
            end
            WR: begin
                if (cur == hi_q) begin
                    state_d = DONE;
                end else begin
                    cur_d   = cur + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state != IDLE) state_d = IDLE;
    end

    // Registered outputs derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            hi_q      <= '0;
            fill_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rf_raddr  <= '0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            rf_wr     <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            cur       <= cur_d;
            hi_q      <= hi_d;
            fill_q    <= fill_d;
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
            rf_wr     <= (state_d == WR);
            out_valid <= (state_d == OUT);
            if (state_d == WR) begin
                rf_waddr <= cur_d[ADDR_W-1:0];
                rf_wdata <= fill_d;
            end
            if (state_d == RD_ADDR) rf_raddr <= cur_d[ADDR_W-1:0];
            if (state == RD_WAIT && state_d == OUT) begin
                out_data <= rf_rdata;
                out_addr <= cur[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Directed bench for regfile_scan_ctrl with a synchronous-read register-file model.
module tb_regfile_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [5:0]  addr_lo;
    logic [5:0]  addr_hi;
    logic [31:0] fill_val;
    logic        abort;
    logic        busy;
    logic        done;
    logic [5:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_addr;
    logic [31:0] out_data;

    regfile_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .addr_lo(addr_lo), .addr_hi(addr_hi), .fill_val(fill_val), .abort(abort),
        .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wr(rf_wr),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model with a backdoor preload port
    logic [31:0] mem [64];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;
    always @(posedge clk) begin
        if (bd_we)      mem[bd_addr] <= bd_data;
        else if (rf_wr) mem[rf_waddr] <= rf_wdata;
        rf_rdata <= mem[rf_raddr];
    end

    int total = 0;
    int bad   = 0;

    // Per-operation observations
    int          nbusy, nvalid, nwr, nwords, nrchg, unstable;
    int          first_valid, first_wr, done_cyc;
    logic        aborted, post_busy, post_done;
    logic [5:0]  w_addr [64];
    logic [31:0] w_data [64];
    logic [5:0]  wr_addr [64];
    logic [31:0] wr_data [64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Issue start in the current cycle (T) and observe cycles T+1.. until done or abort
    task automatic run_op(input logic m, input logic [5:0] lo, input logic [5:0] hi,
                          input logic [31:0] fv, input int stall, input int abort_word,
                          input int budget);
        logic [5:0]  prev_r, ref_a, ref_r;
        logic [31:0] ref_d;
        int          stall_cnt;
        nbusy = 0; nvalid = 0; nwr = 0; nwords = 0; nrchg = 0; unstable = 0;
        first_valid = 0; first_wr = 0; done_cyc = 0; aborted = 1'b0;
        post_busy = 1'bx; post_done = 1'bx;
        stall_cnt = 0; ref_a = '0; ref_r = '0; ref_d = '0;
        prev_r = rf_raddr;
        mode = m; addr_lo = lo; addr_hi = hi; fill_val = fv; start = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            if (aborted) break;
            if (busy) nbusy++;
            if (rf_raddr != prev_r) begin nrchg++; prev_r = rf_raddr; end
            if (rf_wr) begin
                wr_addr[nwr] = rf_waddr;
                wr_data[nwr] = rf_wdata;
                if (nwr == 0) first_wr = k;
                nwr++;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            if (out_valid) begin
                nvalid++;
                if (first_valid == 0) first_valid = k;
                if (nwords == abort_word) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                end else if (stall_cnt < stall) begin
                    if (stall_cnt == 0) begin
                        ref_a = out_addr; ref_d = out_data; ref_r = rf_raddr;
                    end else if (out_addr != ref_a || out_data != ref_d || rf_raddr != ref_r) begin
                        unstable++;
                    end
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    if (stall > 0 && (out_addr != ref_a || out_data != ref_d || rf_raddr != ref_r))
                        unstable++;
                    out_ready = 1'b1;
                    w_addr[nwords] = out_addr;
                    w_data[nwords] = out_data;
                    nwords++;
                    stall_cnt = 0;
                end
            end
        end
        chk("op_finished", 64'(done_cyc != 0 || aborted), 64'(1));
        if (done_cyc != 0) begin
            tick();
            post_busy = busy;
            post_done = done;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; mode = 1'b0; addr_lo = '0; addr_hi = '0;
        fill_val = '0; abort = 1'b0; out_ready = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rf", 64'({rf_wr, rf_raddr, rf_waddr, rf_wdata}), 64'(0));
        chk("rst_out", 64'({out_valid, out_addr, out_data}), 64'(0));

        // Preload: regs 0..3 = 11,22,33,44, others 0x1000+index
        for (int i = 0; i < 64; i++) begin
            bd_we = 1'b1;
            bd_addr = 6'(i);
            bd_data = (i < 4) ? 32'((i + 1) * 11) : 32'h1000 + 32'(i);
            tick();
        end
        bd_we = 1'b0;
        rst_n = 1'b1;
        tick();

        // 1: dump 0..3 with consumer always ready
        run_op(1'b0, 6'd0, 6'd3, 32'h0, 0, -1, 40);
        chk("t1_first_valid", 64'(first_valid), 64'(3));
        chk("t1_done_cyc", 64'(done_cyc), 64'(13));
        chk("t1_nwords", 64'(nwords), 64'(4));
        chk("t1_word0", 64'({w_addr[0], w_data[0]}), 64'({6'd0, 32'd11}));
        chk("t1_word1", 64'({w_addr[1], w_data[1]}), 64'({6'd1, 32'd22}));
        chk("t1_word3", 64'({w_addr[3], w_data[3]}), 64'({6'd3, 32'd44}));
        chk("t1_busy_cycles", 64'(nbusy), 64'(13));
        chk("t1_no_wr", 64'(nwr), 64'(0));
        chk("t1_post", 64'({post_busy, post_done}), 64'(0));

        // 2: fill 5..7, then dump them back
        run_op(1'b1, 6'd5, 6'd7, 32'hDEADBEEF, 0, -1, 20);
        chk("t2_nwr", 64'(nwr), 64'(3));
        chk("t2_first_wr", 64'(first_wr), 64'(1));
        chk("t2_done_cyc", 64'(done_cyc), 64'(4));
        chk("t2_waddr", 64'({wr_addr[0], wr_addr[1], wr_addr[2]}), 64'({6'd5, 6'd6, 6'd7}));
        chk("t2_wdata", 64'(wr_data[2]), 64'(32'hDEADBEEF));
        chk("t2_no_valid", 64'(nvalid), 64'(0));
        run_op(1'b0, 6'd5, 6'd7, 32'h0, 0, -1, 40);
        chk("t2b_nwords", 64'(nwords), 64'(3));
        chk("t2b_data", 64'({w_data[0] ^ w_data[1], w_data[2]}), 64'({32'h0, 32'hDEADBEEF}));
        chk("t2b_addr", 64'({w_addr[0], w_addr[2]}), 64'({6'd5, 6'd7}));

        // 3: dump 0..1 with 5 stall cycles per word
        run_op(1'b0, 6'd0, 6'd1, 32'h0, 5, -1, 60);
        chk("t3_nwords", 64'(nwords), 64'(2));
        chk("t3_word0", 64'({w_addr[0], w_data[0]}), 64'({6'd0, 32'd11}));
        chk("t3_word1", 64'({w_addr[1], w_data[1]}), 64'({6'd1, 32'd22}));
        chk("t3_stable", 64'(unstable), 64'(0));
        chk("t3_raddr_changes", 64'(nrchg), 64'(2));
        chk("t3_done_cyc", 64'(done_cyc), 64'(17));

        // 4: empty range (lo > hi)
        run_op(1'b1, 6'd9, 6'd4, 32'h12345678, 0, -1, 10);
        chk("t4_done_cyc", 64'(done_cyc), 64'(1));
        chk("t4_busy_cycles", 64'(nbusy), 64'(1));
        chk("t4_no_xfer", 64'({nvalid[7:0], nwr[7:0]}), 64'(0));
        chk("t4_reg9_kept", 64'(mem[9]), 64'(32'h1009));

        // 5: abort at the second OUT, then an immediate new start
        run_op(1'b0, 6'd0, 6'd31, 32'h0, 0, 1, 200);
        chk("t5_aborted", 64'(aborted), 64'(1));
        chk("t5_no_done", 64'(done_cyc), 64'(0));
        chk("t5_words_before", 64'(nwords), 64'(1));
        chk("t5_idle_after", 64'({busy, done, out_valid, rf_wr}), 64'(0));
        run_op(1'b0, 6'd2, 6'd2, 32'h0, 0, -1, 20);
        chk("t5b_done_cyc", 64'(done_cyc), 64'(4));
        chk("t5b_word", 64'({w_addr[0], w_data[0]}), 64'({6'd2, 32'd33}));

        // Out-of-range addresses clamp to the last register
        run_op(1'b0, 6'd50, 6'd60, 32'h0, 0, -1, 20);
        chk("clamp_dump_n", 64'(nwords), 64'(1));
        chk("clamp_dump_word", 64'({w_addr[0], w_data[0]}), 64'({6'd31, 32'h101F}));

        // 6: reset in the middle of a fill, on the cycle presenting address 10
        mode = 1'b1; addr_lo = 6'd8; addr_hi = 6'd20; fill_val = 32'h55; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t6_at_10", 64'({rf_wr, rf_waddr}), 64'({1'b1, 6'd10}));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_immediate", 64'({rf_wr, busy, out_valid, done}), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_written", 64'({mem[8], mem[9]}), 64'({32'h55, 32'h55}));
        chk("t6_untouched", 64'({mem[10], mem[11]}), 64'({32'h100A, 32'h100B}));
        chk("t6_untouched_hi", 64'(mem[20]), 64'(32'h1014));
        run_op(1'b1, 6'd31, 6'd31, 32'hCAFE, 0, -1, 10);
        chk("t6b_nwr", 64'(nwr), 64'(1));
        chk("t6b_done_cyc", 64'(done_cyc), 64'(2));
        chk("t6b_mem", 64'({mem[31], mem[30]}), 64'({32'hCAFE, 32'h101E}));
        run_op(1'b1, 6'd40, 6'd45, 32'h77, 0, -1, 10);
        chk("clamp_fill", 64'({nwr[7:0], wr_addr[0]}), 64'({8'd1, 6'd31}));
        chk("clamp_fill_mem", 64'({mem[31], mem[30]}), 64'({32'h77, 32'h101E}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
